// File: rtl/dtack_gen.sv
// dtack_gen: 68010 DTACK generator with per-region wait states, external I/O ack and BERR abort.
// Rev 1.0
`default_nettype none

module dtack_gen #(
  parameter int RAM_WAIT = 0,
  parameter int ROM_WAIT = 2
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_AS_n,
  input  logic i_RAM_CS,
  input  logic i_ROM_CS,
  input  logic i_IO_CS,
  input  logic i_IO_DTACK_n,
  input  logic i_BERR_n,
  output logic o_DTACK_n,
  output logic o_ack,
  output logic o_busy
);

  generate
    if (RAM_WAIT < 0 || RAM_WAIT > 15 || ROM_WAIT < 0 || ROM_WAIT > 15) begin : g_wait_range_err
      $error("dtack_gen: RAM_WAIT and ROM_WAIT must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] c_RAM_N = 4'(RAM_WAIT);
  localparam logic [3:0] c_ROM_N = 4'(ROM_WAIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    EXT   = 3'd2,
    ACK   = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_io_dtack_n;
  logic       r_ack;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (!i_AS_n) begin
          if (i_RAM_CS) begin
            if (c_RAM_N == 4'd0) begin
              w_next = ACK;
            end else begin
              w_next     = COUNT;
              w_cnt_next = c_RAM_N;
            end
          end else if (i_ROM_CS) begin
            if (c_ROM_N == 4'd0) begin
              w_next = ACK;
            end else begin
              w_next     = COUNT;
              w_cnt_next = c_ROM_N;
            end
          end else if (i_IO_CS) begin
            w_next = EXT;
          end
        end
      end
      COUNT: begin
        // Bus error outranks both a strobe release and the terminal count.
        if (!i_BERR_n) begin
          w_next     = ABORT;
          w_cnt_next = 4'd0;
        end else if (i_AS_n) begin
          w_next     = IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_next     = ACK;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      EXT: begin
        if (!i_BERR_n) begin
          w_next = ABORT;
        end else if (i_AS_n) begin
          w_next = IDLE;
        end else if (!r_io_dtack_n) begin
          w_next = ACK;
        end
      end
      ACK: begin
        if (!i_BERR_n) begin
          w_next = ABORT;
        end else if (i_AS_n) begin
          w_next = IDLE;
        end
      end
      ABORT: begin
        if (i_AS_n) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // Peripheral ack is registered once, so EXT reaches ACK on the edge after it is seen low.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_io_dtack_n <= 1'b1;
      r_ack        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_io_dtack_n <= i_IO_DTACK_n;
      r_ack        <= (w_next == ACK);
    end
  end

  assign o_ack     = r_ack;
  assign o_busy    = (r_state != IDLE);
  assign o_DTACK_n = r_ack ? 1'b0 : 1'bz;

endmodule

`default_nettype wire

// File: doc/dtack_gen.md
DTACK_GEN -- requirements
Module: dtack_gen

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 0: wait states inserted for RAM cycles, range 0-15.
REQ-002 SHALL have parameter ROM_WAIT, default 2: wait states inserted for ROM cycles, range 0-15.
REQ-003 SHALL use one clock, i_CLK; reset i_RST is asynchronous and active-high.
REQ-004 i_CLK  input  1  CPU bus clock; all state changes occur on its rising edge.
REQ-005 i_RST  input  1  asynchronous, active-high reset.
REQ-006 i_AS_n  input  1  68010 address strobe, active low.
REQ-007 i_RAM_CS  input  1  decoded RAM select, active high.
REQ-008 i_ROM_CS  input  1  decoded ROM select, active high.
REQ-009 i_IO_CS  input  1  decoded I/O select, active high; the peripheral supplies its own acknowledge.
REQ-010 i_IO_DTACK_n  input  1  peripheral acknowledge, active low.
REQ-011 i_BERR_n  input  1  bus error line from the watchdog, active low.
REQ-012 o_DTACK_n  output  1  open-drain DTACK: drives 0 when acknowledging, otherwise high-Z.
REQ-013 o_ack  output  1  internal drive-enable for o_DTACK_n; must be a real output so the tri-state logic works.
REQ-014 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, COUNT, EXT, ACK and ABORT; all inputs are sampled on the rising edge of i_CLK.
REQ-016 In IDLE, when i_AS_n is sampled low, the select priority SHALL be RAM > ROM > IO. Only the highest-priority asserted select is acted on.
REQ-017 In IDLE with i_AS_n low and the selected region's wait count N = 0, the block SHALL go to ACK on that same edge k.
REQ-018 In IDLE with i_AS_n low and N >= 1, the block SHALL go to COUNT and load the 4-bit counter with N.
REQ-019 In COUNT, if counter == 1 the block SHALL go to ACK; otherwise the counter SHALL decrement. Net effect: ACK is entered on edge k+N.
REQ-020 In IDLE with i_AS_n low and only i_IO_CS set, the block SHALL go to EXT.
REQ-021 In EXT, when i_IO_DTACK_n is sampled low the block SHALL go to ACK on the next edge; there is no timeout here, because the watchdog owns timeouts.
REQ-022 In IDLE with i_AS_n low and no select asserted, the block SHALL stay in IDLE and never acknowledge; the watchdog then raises BERR.
REQ-023 In ACK, o_ack SHALL be 1 and o_DTACK_n SHALL be 0. The block SHALL stay in ACK until i_AS_n is sampled high, then return to IDLE.
REQ-024 In COUNT or EXT, if i_AS_n is sampled high the block SHALL return to IDLE without acknowledging, and the counter SHALL clear to 0.
REQ-025 In COUNT, EXT or ACK, if i_BERR_n is sampled low the block SHALL go to ABORT, with o_ack = 0 from that edge. BERR takes priority over a simultaneous ACK condition.
REQ-026 ABORT SHALL hold o_ack at 0 until i_AS_n is sampled high, then return to IDLE. A new cycle SHALL NOT start from ABORT.
REQ-027 i_BERR_n low while in IDLE SHALL have no effect. Select inputs SHALL be ignored in every state except IDLE.
REQ-028 o_DTACK_n SHALL be high-Z whenever o_ack = 0. o_busy SHALL equal (state != IDLE).
REQ-029 Counter arithmetic SHALL be 4-bit unsigned; wait values above 15 are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-030 While i_RST is high, the block SHALL hold: state IDLE, counter 0, o_ack 0, o_DTACK_n high-Z, o_busy 0. This takes effect immediately, independent of i_CLK.
REQ-031 Asserting i_RST mid-cycle, including in ACK, SHALL release o_DTACK_n at once. After release, the block SHALL start only from a fresh i_AS_n low sample in IDLE.

Verification
REQ-032 RAM, RAM_WAIT = 0: i_AS_n low with i_RAM_CS = 1 at edge 0 -> o_DTACK_n = 0 after edge 0; i_AS_n high at edge 3 -> o_DTACK_n = Z and o_busy = 0 after edge 3.
REQ-033 ROM, ROM_WAIT = 2: i_AS_n low with i_ROM_CS = 1 at edge 0 -> o_DTACK_n stays Z after edges 0 and 1, goes 0 after edge 2, and releases one edge after i_AS_n returns high.
REQ-034 IO: i_AS_n low with i_IO_CS = 1; i_IO_DTACK_n low at edge 5 -> o_DTACK_n = 0 after edge 6.
REQ-035 Bus error: i_AS_n low with i_IO_CS = 1 and i_IO_DTACK_n held high; i_BERR_n low at edge 128 -> o_DTACK_n stays Z and o_busy stays 1 until i_AS_n goes high. A simultaneous i_IO_DTACK_n low on edge 128 also yields no acknowledge.
REQ-036 Priority and reset: i_RAM_CS = i_ROM_CS = 1 with RAM_WAIT = 0 and ROM_WAIT = 2 -> acknowledge after edge 0. Then i_RST pulsed while in ACK -> o_DTACK_n = Z immediately and all outputs at reset values.
